// File: rtl/bus_mem_slave.sv
`default_nettype none
// ============================================================================
// Module      : bus_mem_slave
// Description : 8088-style T1/T2/Tw/T3 memory responder backed by a byte RAM.
//               Optional out-of-range checking via BUS_RANGE_CHECK_EN.
// Revision    : 1.0  initial release
// ============================================================================
module bus_mem_slave #(
    parameter int ADDR_W      = 20,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              rd_wr,
    input  logic [ADDR_W-1:0] direction,
    input  logic [7:0]        data_wr,
    output logic [7:0]        data_rd,
    output logic              data_oe,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    localparam int         IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        TW   = 3'd3,
        T3   = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [2:0]         r_wait;
    logic               r_rd_wr;
    logic [ADDR_W-1:0]  r_addr;
    logic [7:0]         r_wdata;
    logic [IDX_W-1:0]   r_index;
    logic [7:0]         r_rd_hold;
    logic [7:0]         mem [MEM_DEPTH];
    logic               w_oor;
    logic               w_t3;
    logic [7:0]         w_rd_val;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (req) w_next = T1;
            T1:   w_next = T2;
            T2:   w_next = (WAIT_STATES > 0) ? TW : T3;
            TW:   if (r_wait == 3'd0) w_next = T3;
            T3:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait    <= 3'd0;
            r_rd_wr   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= 8'h00;
            r_index   <= '0;
            r_rd_hold <= 8'h00;
        end else begin
            if (r_state == IDLE && req) begin
                r_rd_wr <= rd_wr;
                r_addr  <= direction;
                r_wdata <= data_wr;
            end
            if (r_state == T1) begin
                r_index <= r_addr[IDX_W-1:0];
            end
            if (r_state == T2) begin
                r_wait <= WAIT_LOAD;
            end else if (r_state == TW && r_wait != 3'd0) begin
                r_wait <= r_wait - 3'd1;
            end
            if (w_t3 && r_rd_wr) begin
                r_rd_hold <= w_rd_val;
            end
        end
    end

`ifdef BUS_RANGE_CHECK_EN
    logic r_oor;

    // Anything above the RAM's index bits is out of range.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_oor <= 1'b0;
        end else if (r_state == T1) begin
            r_oor <= (r_addr >> IDX_W) != '0;
        end
    end
    assign w_oor = r_oor;
`else
    logic w_unused_addr;
    assign w_unused_addr = ^r_addr;
    assign w_oor         = 1'b0;
`endif

    // A reset landing in T3 aborts the cycle, so the write is gated too.
    always_ff @(posedge clk) begin
        if (!reset && w_t3 && !r_rd_wr && !w_oor) begin
            mem[r_index] <= r_wdata;
        end
    end

    assign w_t3     = (r_state == T3);
    assign w_rd_val = w_oor ? 8'hFF : mem[r_index];

    assign ready    = w_t3;
    assign busy     = (r_state != IDLE);
    assign data_oe  = w_t3 & r_rd_wr;
    assign data_rd  = data_oe ? w_rd_val : r_rd_hold;
    assign err      = w_t3 & w_oor;

endmodule
`default_nettype wire

// File: tb/tb_bus_mem_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_mem_slave
// Description : Randomised self-checking bench for bus_mem_slave at wait
//               states 0, 1 and 7 against an array memory model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_bus_mem_slave;

    localparam int AW    = 20;
    localparam int DEPTH = 256;

    logic            clk   = 1'b0;
    logic            reset = 1'b1;
    logic            req_a   [3];
    logic            rd_wr_a [3];
    logic [AW-1:0]   dir_a   [3];
    logic [7:0]      wr_a    [3];
    logic [7:0]      rd_a    [3];
    logic            oe_a    [3];
    logic            rdy_a   [3];
    logic            busy_a  [3];
    logic            err_a   [3];

    int              checks   = 0;
    int              failures = 0;
    int              ws_of [3] = '{0, 1, 7};
    logic [7:0]      ref_mem [3][DEPTH];
    logic [7:0]      last_rd [3];

    always #5 clk = ~clk;

    bus_mem_slave #(.ADDR_W(AW), .MEM_DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .reset(reset), .req(req_a[0]), .rd_wr(rd_wr_a[0]),
        .direction(dir_a[0]), .data_wr(wr_a[0]), .data_rd(rd_a[0]),
        .data_oe(oe_a[0]), .ready(rdy_a[0]), .busy(busy_a[0]), .err(err_a[0]));

    bus_mem_slave #(.ADDR_W(AW), .MEM_DEPTH(DEPTH), .WAIT_STATES(1)) u_ws1 (
        .clk(clk), .reset(reset), .req(req_a[1]), .rd_wr(rd_wr_a[1]),
        .direction(dir_a[1]), .data_wr(wr_a[1]), .data_rd(rd_a[1]),
        .data_oe(oe_a[1]), .ready(rdy_a[1]), .busy(busy_a[1]), .err(err_a[1]));

    bus_mem_slave #(.ADDR_W(AW), .MEM_DEPTH(DEPTH), .WAIT_STATES(7)) u_ws7 (
        .clk(clk), .reset(reset), .req(req_a[2]), .rd_wr(rd_wr_a[2]),
        .direction(dir_a[2]), .data_wr(wr_a[2]), .data_rd(rd_a[2]),
        .data_oe(oe_a[2]), .ready(rdy_a[2]), .busy(busy_a[2]), .err(err_a[2]));

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_oor(input logic [AW-1:0] a);
`ifdef BUS_RANGE_CHECK_EN
        return int'(a) >= DEPTH;
`else
        return 1'b0;
`endif
    endfunction

    // One complete bus cycle on instance d, checked against the model.
    task automatic do_access(input int d, input bit rd, input logic [AW-1:0] a,
                             input logic [7:0] wd);
        int         n;
        int         idx;
        bit         oor;
        logic [7:0] exp_rd;
        idx = int'(a) % DEPTH;
        oor = is_oor(a);
        @(negedge clk);
        req_a[d] = 1'b1; rd_wr_a[d] = rd; dir_a[d] = a; wr_a[d] = wd;
        @(negedge clk);
        req_a[d] = 1'b0;
        n = 1;
        check_val("busy_t1", 32'(busy_a[d]), 32'd1);
        while (!rdy_a[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rdy_a[d]) begin
            check_val("ready_timeout", 32'(rdy_a[d]), 32'd1);
            return;
        end
        check_val("latency", 32'(n), 32'(3 + ws_of[d]));
        check_val("err", 32'(err_a[d]), 32'(oor));
        if (rd) begin
            exp_rd = oor ? 8'hFF : ref_mem[d][idx];
            check_val("rd_oe", 32'(oe_a[d]), 32'd1);
            check_val("rd_data", 32'(rd_a[d]), 32'(exp_rd));
            last_rd[d] = exp_rd;
        end else begin
            check_val("wr_oe", 32'(oe_a[d]), 32'd0);
            if (!oor) ref_mem[d][idx] = wd;
        end
        @(negedge clk);
        check_val("ready_width", 32'(rdy_a[d]), 32'd0);
        check_val("busy_after", 32'(busy_a[d]), 32'd0);
        check_val("oe_after", 32'(oe_a[d]), 32'd0);
        check_val("rd_hold", 32'(rd_a[d]), 32'(last_rd[d]));
    endtask

    task automatic check_idle_all(input string tag);
        for (int d = 0; d < 3; d++) begin
            check_val({tag, "_ready"}, 32'(rdy_a[d]), 32'd0);
            check_val({tag, "_busy"}, 32'(busy_a[d]), 32'd0);
            check_val({tag, "_oe"}, 32'(oe_a[d]), 32'd0);
            check_val({tag, "_err"}, 32'(err_a[d]), 32'd0);
            check_val({tag, "_rd"}, 32'(rd_a[d]), 32'(last_rd[d]));
        end
    endtask

    initial begin
        int         nrdy;
        bit         rd;
        logic [AW-1:0] a;
        for (int d = 0; d < 3; d++) begin
            req_a[d] = 1'b0; rd_wr_a[d] = 1'b0; dir_a[d] = '0; wr_a[d] = 8'h00;
            last_rd[d] = 8'h00;
            for (int i = 0; i < DEPTH; i++) ref_mem[d][i] = 8'h00;
        end

        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_idle_all("reset_idle");
        end

        do_access(1, 1'b0, 20'h00010, 8'hA5);
        do_access(1, 1'b1, 20'h00010, 8'h00);

        do_access(0, 1'b0, 20'h00020, 8'h5A);
        do_access(0, 1'b1, 20'h00020, 8'h00);
        do_access(2, 1'b0, 20'h00030, 8'hC3);
        do_access(2, 1'b1, 20'h00030, 8'h00);

        // Second request during T2 must be dropped.
        do_access(1, 1'b0, 20'h00005, 8'h3C);
        @(negedge clk);
        req_a[1] = 1'b1; rd_wr_a[1] = 1'b1; dir_a[1] = 20'h00005;
        @(negedge clk);
        req_a[1] = 1'b0;
        @(negedge clk);
        req_a[1] = 1'b1;
        @(negedge clk);
        req_a[1] = 1'b0;
        nrdy = 0;
        for (int c = 0; c < 15; c++) begin
            if (rdy_a[1]) begin
                nrdy++;
                check_val("drop_rd_data", 32'(rd_a[1]), 32'h3C);
            end
            @(negedge clk);
        end
        check_val("drop_ready_count", 32'(nrdy), 32'd1);
        check_val("drop_busy", 32'(busy_a[1]), 32'd0);
        last_rd[1] = 8'h3C;

        // Reset during T2 of a write aborts it.
        @(negedge clk);
        req_a[1] = 1'b1; rd_wr_a[1] = 1'b0; dir_a[1] = 20'h00005; wr_a[1] = 8'h77;
        @(negedge clk);
        req_a[1] = 1'b0;
        @(negedge clk);
        check_val("abort_in_t2", 32'(busy_a[1]), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int d = 0; d < 3; d++) last_rd[d] = 8'h00;
        check_idle_all("mid_reset");
        do_access(1, 1'b1, 20'h00005, 8'h00);

        do_access(1, 1'b0, 20'h00105, 8'h11);
        do_access(1, 1'b1, 20'h00105, 8'h00);
        do_access(1, 1'b1, 20'h00005, 8'h00);

        for (int i = 0; i < 16; i++) do_access(1, 1'b0, AW'(i), 8'($urandom));
        for (int i = 0; i < 40; i++) begin
            rd = 1'($urandom_range(0, 1));
            a  = AW'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) a = a + AW'(256);
            do_access(1, rd, a, 8'($urandom));
        end
        for (int i = 0; i < 6; i++) begin
            a = AW'($urandom_range(64, 71));
            do_access(0, 1'b0, a, 8'($urandom));
            do_access(0, 1'b1, a, 8'h00);
            do_access(2, 1'b0, a, 8'($urandom));
            do_access(2, 1'b1, a, 8'h00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
